// File: rtl/useq_pkg.sv
// Shared definitions for the micro-sequencer and its control ROM: sizes,
// microword field positions, branch-condition and sequencer-state encodings.
package useq_pkg;

  localparam int USEQ_AW        = 5;
  localparam int USEQ_DW        = 23;
  localparam int USEQ_CW        = 15;
  localparam int USEQ_DEPTH     = 18;
  localparam int USEQ_HALT_ADDR = 17;
  localparam int USEQ_CNT_W     = 4;

  localparam int F_COND_HI = 22;
  localparam int F_COND_LO = 20;
  localparam int F_NEXT_HI = 19;
  localparam int F_NEXT_LO = 15;
  localparam int F_CTL_HI  = 14;
  localparam int F_CTL_LO  = 0;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_LSB    = 3'd2,
    COND_SIGN   = 3'd3,
    COND_CNT    = 3'd4
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Assembles one microword; lets ROM images be written symbolically.
  function automatic logic [USEQ_DW-1:0] useq_word(
    input cond_e                 c,
    input logic [USEQ_AW-1:0]    nxt,
    input logic [USEQ_CW-1:0]    ctl
  );
    return {c, nxt, ctl};
  endfunction

endpackage

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks a combinational control ROM from address 0,
// branching on datapath flags or a loop counter, until the halt word or an illegal address.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int AW        = USEQ_AW,
  parameter int DW        = USEQ_DW,
  parameter int CW        = USEQ_CW,
  parameter int DEPTH     = USEQ_DEPTH,
  parameter int HALT_ADDR = USEQ_HALT_ADDR,
  parameter int CNT_W     = USEQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt_init,
  input  logic             flag_z,
  input  logic             flag_lsb,
  input  logic             flag_sign,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data,
  output logic [CW-1:0]    ctrl,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One extra bit so the range test sees the true value of DEPTH.
  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] HALT_PC   = AW'(HALT_ADDR);

  state_e           state_q, state_d;
  logic [AW-1:0]    upc_q, upc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  cond_e            cond;
  logic [AW-1:0]    next_f;
  logic [CW-1:0]    ctl_f;
  logic             take;
  logic             cnt_dec;
  logic [AW-1:0]    target;
  logic             in_run;

  assign cond   = cond_e'(rom_data[F_COND_HI:F_COND_LO]);
  assign next_f = rom_data[F_NEXT_HI:F_NEXT_LO];
  assign ctl_f  = rom_data[F_CTL_HI:F_CTL_LO];

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    take    = 1'b0;
    cnt_dec = 1'b0;

    case (cond)
      COND_Z:    take = flag_z;
      COND_LSB:  take = flag_lsb;
      COND_SIGN: take = flag_sign;
      COND_CNT: begin
        take    = (cnt_q != '0);
        cnt_dec = take;
      end
      default:   take = 1'b1;
    endcase

    target = take ? next_f : upc_q + AW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          upc_d   = '0;
          cnt_d   = cnt_init;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (upc_q == HALT_PC) begin
          state_d = ST_DONE;
        end else if ({1'b0, target} >= DEPTH_LIM) begin
          // The offending word is never fetched: stop on this edge.
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          upc_d = target;
          if (cnt_dec) cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_run   = (state_q == ST_RUN);
  assign rom_addr = in_run ? upc_q : '0;
  assign ctrl     = in_run ? ctl_f : '0;
  assign busy     = in_run;
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: a behavioural program interpreter
// predicts the address trace, control words and completion status of each run.
module tb_micro_sequencer;

  localparam int MAXT = 1024;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  cnt_init;
  logic        flag_z;
  logic        flag_lsb;
  logic        flag_sign;
  logic [4:0]  rom_addr;
  logic [22:0] rom_data;
  logic [14:0] ctrl;
  logic        busy;
  logic        done;
  logic        err;

  logic [22:0] rom [0:31];
  bit          fz [0:MAXT-1];
  bit          fl [0:MAXT-1];
  bit          fs [0:MAXT-1];
  int          exp_addr [0:MAXT-1];
  int          exp_n;
  bit          exp_err;
  int          checks;
  int          passed;

  micro_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .cnt_init  (cnt_init),
    .flag_z    (flag_z),
    .flag_lsb  (flag_lsb),
    .flag_sign (flag_sign),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ctrl      (ctrl),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Program interpreter: follows the microprogram rules directly.
  function automatic void build_expected(input logic [3:0] ci);
    int pc;
    int cnt;
    int k;
    int c;
    int nx;
    int np;
    bit tk;
    pc = 0;
    cnt = int'(ci);
    k = 0;
    exp_err = 1'b0;
    for (int guard = 0; guard < MAXT; guard++) begin
      exp_addr[k] = pc;
      k++;
      if (pc == 17 || k >= MAXT) break;
      c  = int'(rom[pc][22:20]);
      nx = int'(rom[pc][19:15]);
      case (c)
        1: tk = fz[k-1];
        2: tk = fl[k-1];
        3: tk = fs[k-1];
        4: begin
          tk = (cnt > 0);
          if (tk) cnt--;
        end
        default: tk = 1'b1;
      endcase
      np = tk ? nx : (pc + 1) % 32;
      if (np >= 18) begin
        exp_err = 1'b1;
        break;
      end
      pc = np;
    end
    exp_n = k;
  endfunction

  function automatic void gen_flags(input bit force_z, input bit zval);
    for (int i = 0; i < MAXT; i++) begin
      fz[i] = force_z ? zval : bit'($urandom_range(0, 1));
      fl[i] = bit'($urandom_range(0, 1));
      fs[i] = bit'($urandom_range(0, 1));
    end
  endfunction

  function automatic void load_linear();
    for (int i = 0; i < 32; i++) begin
      if (i < 17) rom[i] = {3'd0, 5'(i + 1), 15'($urandom) | 15'd1};
      else        rom[i] = {3'd0, 5'd25, 15'($urandom) | 15'd1};
    end
  endfunction

  task automatic run_program(input bit hold, input bit pre_started,
                             input logic [3:0] ci, input string nm);
    build_expected(ci);
    if (pre_started) begin
      cnt_init = ci;
    end else begin
      @(negedge clk);
      start    = 1'b1;
      cnt_init = ci;
    end
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int k = 0; k < exp_n; k++) begin
      flag_z    = fz[k];
      flag_lsb  = fl[k];
      flag_sign = fs[k];
      @(negedge clk);
      checks++;
      if (rom_addr !== 5'(exp_addr[k]))
        $display("FAIL %s addr cycle %0d: got %0d expected %0d", nm, k, rom_addr, exp_addr[k]);
      else passed++;
      checks++;
      if (ctrl !== rom[exp_addr[k]][14:0])
        $display("FAIL %s ctrl cycle %0d: got %h expected %h", nm, k, ctrl, rom[exp_addr[k]][14:0]);
      else passed++;
      checks++;
      if ({busy, done, err} !== 3'b100)
        $display("FAIL %s run status cycle %0d: busy/done/err got %b expected 100", nm, k, {busy, done, err});
      else passed++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({done, err, busy} !== {1'b1, exp_err, 1'b0})
      $display("FAIL %s done status: done/err/busy got %b expected %b", nm, {done, err, busy}, {1'b1, exp_err, 1'b0});
    else passed++;
    checks++;
    if ({ctrl, rom_addr} !== 20'd0)
      $display("FAIL %s done outputs: ctrl %h addr %0d expected 0", nm, ctrl, rom_addr);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL %s idle after done: busy/done got %b expected 00", nm, {busy, done});
    else passed++;
    $display("run %s: %0d words, err=%0d", nm, exp_n, exp_err);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b1;
    cnt_init = 4'd0;
    flag_z = 1'b0; flag_lsb = 1'b0; flag_sign = 1'b0;
    load_linear();
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_addr, ctrl, busy, done, err} !== 23'd0)
      $display("FAIL reset outputs: got %h expected 0", {rom_addr, ctrl, busy, done, err});
    else passed++;
    start = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_addr, ctrl, busy, done, err} !== 23'd0)
      $display("FAIL idle after reset: got %h expected 0", {rom_addr, ctrl, busy, done, err});
    else passed++;
  endtask

  task automatic test_reset_midrun();
    load_linear();
    @(negedge clk);
    start = 1'b1;
    cnt_init = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if ({busy, rom_addr} !== {1'b1, 5'd5})
      $display("FAIL midrun before reset: busy/addr got %b/%0d expected 1/5", busy, rom_addr);
    else passed++;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rom_addr, ctrl, busy, done} !== 22'd0)
      $display("FAIL midrun async reset: got %h expected 0", {rom_addr, ctrl, busy, done});
    else passed++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, rom_addr} !== 7'd0)
        $display("FAIL after midrun reset cycle %0d: busy/done/addr got %b expected 0", i, {busy, done, rom_addr});
      else passed++;
    end
    $display("run reset_midrun: outputs cleared, no restart");
  endtask

  task automatic test_linear();
    load_linear();
    gen_flags(1'b0, 1'b0);
    run_program(1'b0, 1'b0, 4'($urandom), "linear");
  endtask

  task automatic test_branch();
    load_linear();
    rom[3] = {3'd1, 5'd12, 15'h4a5b};
    gen_flags(1'b1, 1'b1);
    run_program(1'b0, 1'b0, 4'd0, "branch_z1");
    gen_flags(1'b1, 1'b0);
    run_program(1'b0, 1'b0, 4'd0, "branch_z0");
    rom[3] = {3'd2, 5'd9, 15'h1234};
    rom[10] = {3'd3, 5'd14, 15'h7001};
    gen_flags(1'b0, 1'b0);
    run_program(1'b0, 1'b0, 4'd0, "branch_lsb_sign");
  endtask

  task automatic test_counter();
    load_linear();
    rom[11] = {3'd4, 5'd3, 15'h0b0b};
    gen_flags(1'b0, 1'b0);
    run_program(1'b0, 1'b0, 4'd3, "counter3");
    run_program(1'b0, 1'b0, 4'd0, "counter0");
  endtask

  task automatic test_illegal();
    load_linear();
    rom[5] = {3'd0, 5'd25, 15'h5555};
    gen_flags(1'b0, 1'b0);
    run_program(1'b0, 1'b0, 4'd0, "illegal");
  endtask

  task automatic test_start_held();
    load_linear();
    rom[5] = {3'd0, 5'd25, 15'h2222};
    gen_flags(1'b0, 1'b0);
    run_program(1'b1, 1'b0, 4'd0, "held_first");
    load_linear();
    gen_flags(1'b0, 1'b0);
    run_program(1'b0, 1'b1, 4'd2, "held_restart");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int pc = 0; pc < 32; pc++) begin
        logic [2:0] c;
        logic [4:0] nx;
        c = 3'($urandom_range(0, 7));
        if (c == 3'd4) nx = 5'($urandom_range(0, 17));
        else           nx = 5'(pc + 1 + int'($urandom_range(0, 2)));
        rom[pc] = {c, nx, 15'($urandom)};
      end
      gen_flags(1'b0, 1'b0);
      run_program(1'b0, 1'b0, 4'($urandom), $sformatf("random%0d", r));
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_linear();
    test_branch();
    test_counter();
    test_illegal();
    test_start_held();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
